// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Definitions shared by the 2:1 stream mux and the 1:2 stream demux.
//   DEFAULT_WIDTH : default data word width
//   SEL_OUT0      : select encoding routing a word to output 0
//   SEL_OUT1      : select encoding routing a word to output 1
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam int   DEFAULT_WIDTH = 8;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

endpackage : mux_pkg

// File: rtl/demux_out_slot.sv
// ---------------------------------------------------------------------------
// demux_out_slot
// One-entry registered output slot of the stream demux. The slot is loaded by
// the upstream accept logic and drained by the downstream valid/ready
// handshake. A load in the same cycle as a drain replaces the word, so the
// slot sustains one word per cycle.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset, empties the slot and clears data
//   load       : write load_data into the slot this cycle
//   load_data  : word to store
//   data       : registered slot word (downstream data)
//   valid      : registered slot-full flag (downstream valid)
//   ready      : downstream consumer ready
//   slot_ready : slot can take a word this cycle (empty, or draining now)
// ---------------------------------------------------------------------------
module demux_out_slot
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             slot_ready
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;

    // Slot register: load wins over drain so drain+fill keeps the slot full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign data       = data_r;
    assign valid      = valid_r;
    assign slot_ready = !valid_r || ready;

endmodule : demux_out_slot

// File: rtl/stream_demux.sv
// ---------------------------------------------------------------------------
// stream_demux
// 1-to-2 registered valid/ready stream demultiplexer. Each input word is
// routed by its in_select to out0 (SEL_OUT0) or out1 (SEL_OUT1) through a
// one-word register slot per output. A stall on one output only blocks words
// selected for that output; in_ready depends on the addressed slot alone.
// Optional feature macro: DEMUX_COUNT_EN adds per-output handshake counters
// cnt0/cnt1 (width COUNT_W, wrapping). Without it the ports and the COUNT_W
// parameter are absent and the datapath is unchanged.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_data/valid/select  : input word, valid, destination
//   in_ready              : input accepted when in_valid && in_ready
//   out0_data/valid/ready : output 0 stream
//   out1_data/valid/ready : output 1 stream
//   cnt0, cnt1            : handshake counters (DEMUX_COUNT_EN only)
// ---------------------------------------------------------------------------
module stream_demux
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef DEMUX_COUNT_EN
    ,
    parameter int COUNT_W = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    input  logic               in_select,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out0_data,
    output logic               out0_valid,
    input  logic               out0_ready,
    output logic [WIDTH-1:0]   out1_data,
    output logic               out1_valid,
    input  logic               out1_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [COUNT_W-1:0] cnt0,
    output logic [COUNT_W-1:0] cnt1
`endif
);

    logic slot0_ready_s;
    logic slot1_ready_s;
    logic in_ready_s;
    logic accept_s;
    logic load0_s;
    logic load1_s;

    // Ready toward the producer follows the slot addressed by this word only.
    always_comb begin
        in_ready_s = 1'b0;
        case (in_select)
            SEL_OUT0: in_ready_s = slot0_ready_s;
            SEL_OUT1: in_ready_s = slot1_ready_s;
            default:  in_ready_s = 1'b0;
        endcase
    end

    assign in_ready = in_ready_s;
    assign accept_s = in_valid && in_ready_s;
    assign load0_s  = accept_s && (in_select == SEL_OUT0);
    assign load1_s  = accept_s && (in_select == SEL_OUT1);

    demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load0_s),
        .load_data  (in_data),
        .data       (out0_data),
        .valid      (out0_valid),
        .ready      (out0_ready),
        .slot_ready (slot0_ready_s)
    );

    demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load1_s),
        .load_data  (in_data),
        .data       (out1_data),
        .valid      (out1_valid),
        .ready      (out1_ready),
        .slot_ready (slot1_ready_s)
    );

`ifdef DEMUX_COUNT_EN
    logic [COUNT_W-1:0] cnt0_r;
    logic [COUNT_W-1:0] cnt1_r;

    // Output 0 handshake counter, wraps naturally at 2^COUNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_r <= {COUNT_W{1'b0}};
        end else if (out0_valid && out0_ready) begin
            cnt0_r <= cnt0_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt0_r <= cnt0_r;
        end
    end

    // Output 1 handshake counter, wraps naturally at 2^COUNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt1_r <= {COUNT_W{1'b0}};
        end else if (out1_valid && out1_ready) begin
            cnt1_r <= cnt1_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt1_r <= cnt1_r;
        end
    end

    assign cnt0 = cnt0_r;
    assign cnt1 = cnt1_r;
`endif

endmodule : stream_demux

// File: tb/tb_stream_demux.sv
// ---------------------------------------------------------------------------
// tb_stream_demux
// Table-driven bench for stream_demux (WIDTH=8). Each table row is one clock
// cycle: inputs, the expected combinational in_ready before the edge and the
// expected registered outputs after it. Hand-written sequences then cover a
// long stall with traffic on the other output and, with DEMUX_COUNT_EN, the
// counter wrap (COUNT_W=8).
// ---------------------------------------------------------------------------
module tb_stream_demux;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_select;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
`ifdef DEMUX_COUNT_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
`endif

    int checks;
    int errors;

`ifdef DEMUX_COUNT_EN
    stream_demux #(.WIDTH(8), .COUNT_W(8)) dut (
`else
    stream_demux #(.WIDTH(8)) dut (
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_select  (in_select),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       v;
        logic       sel;
        logic [7:0] d;
        logic       r0;
        logic       r1;
        logic       ck;   // check in_ready this row
        logic       rdy;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic rs, input logic v, input logic sel,
                                input logic [7:0] d, input logic r0, input logic r1,
                                input logic ck, input logic rdy, input logic v0,
                                input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        vec_t t;
        t.rst_n = rs; t.v = v; t.sel = sel; t.d = d; t.r0 = r0; t.r1 = r1;
        t.ck = ck; t.rdy = rdy; t.v0 = v0; t.d0 = d0; t.v1 = v1; t.d1 = d1;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic v, input logic sel,
                         input logic [7:0] d, input logic r0, input logic r1);
        rst_n = rs; in_valid = v; in_select = sel; in_data = d;
        out0_ready = r0; out1_ready = r1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        //           rst   v     sel   d      r0    r1    ck    rdy   v0    d0     v1    d1
        // reset, two cycles
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        // single word to out0, drains next cycle
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 8'h00);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        // alternating selects 01..08
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00);
        tbl[5]  = mk(1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00);
        tbl[7]  = mk(1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 8'h00);
        tbl[9]  = mk(1'b1, 1'b1, 1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h06);
        tbl[10] = mk(1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 8'h00);
        tbl[11] = mk(1'b1, 1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h08);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        // back-to-back to out0: simultaneous drain and refill
        tbl[13] = mk(1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00);
        tbl[14] = mk(1'b1, 1'b1, 1'b0, 8'h12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 8'h00);
        tbl[15] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        // out1 stalled: CC held, 33 passes out0, 0F blocked until release
        tbl[16] = mk(1'b1, 1'b1, 1'b1, 8'hCC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hCC);
        tbl[17] = mk(1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 8'hCC);
        tbl[18] = mk(1'b1, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hCC);
        tbl[19] = mk(1'b1, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hCC);
        tbl[20] = mk(1'b1, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0F);
        tbl[21] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        // 55 held on out0, then reset discards it
        tbl[22] = mk(1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 8'h00);
        tbl[23] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
        tbl[24] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        tbl[25] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

        @(posedge clk);
        #1;
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst_n, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
            #1;
            if (tbl[i].ck)
                check($sformatf("row%0d in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].rdy});
            @(posedge clk);
            #1;
            check($sformatf("row%0d out0_valid", i), {31'd0, out0_valid}, {31'd0, tbl[i].v0});
            check($sformatf("row%0d out1_valid", i), {31'd0, out1_valid}, {31'd0, tbl[i].v1});
            if (tbl[i].v0 || !tbl[i].rst_n)
                check($sformatf("row%0d out0_data", i), {24'd0, out0_data}, {24'd0, tbl[i].d0});
            if (tbl[i].v1 || !tbl[i].rst_n)
                check($sformatf("row%0d out1_data", i), {24'd0, out1_data}, {24'd0, tbl[i].d1});
        end

        // Long stall on out0 while out1 keeps flowing; held word must not move.
        drive(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1);
        #1;
        check("stall load rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("stall v0", {31'd0, out0_valid}, 32'd1);
        check("stall d0", {24'd0, out0_data}, 32'h5A);
        drive(1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 1'b1);
        #1;
        check("other output rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("other output v1", {31'd0, out1_valid}, 32'd1);
        check("other output d1", {24'd0, out1_data}, 32'h66);
        check("other output d0 held", {24'd0, out0_data}, 32'h5A);
        drive(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
        #1;
        check("blocked rdy", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("blocked d0 held", {24'd0, out0_data}, 32'h5A);
        check("blocked v1 drained", {31'd0, out1_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            @(posedge clk); #1;
            check($sformatf("hold%0d v0", k), {31'd0, out0_valid}, 32'd1);
            check($sformatf("hold%0d d0", k), {24'd0, out0_data}, 32'h5A);
        end
        begin
            logic seen;
            seen = 1'b0;
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            for (int k = 0; k < 8 && !seen; k++) begin
                #1;
                if (out0_valid && out0_ready) seen = 1'b1;
                @(posedge clk); #1;
            end
            check("release handshake seen", {31'd0, seen}, 32'd1);
            check("release v0", {31'd0, out0_valid}, 32'd0);
        end

`ifdef DEMUX_COUNT_EN
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("cnt0 reset", {24'd0, cnt0}, 32'd0);
        check("cnt1 reset", {24'd0, cnt1}, 32'd0);
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 1'b1, 1'b0, k[7:0], 1'b1, 1'b1);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b1, k[7:0], 1'b1, 1'b1);
            @(posedge clk); #1;
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("cnt0 wrapped", {24'd0, cnt0}, 32'd44);
        check("cnt1", {24'd0, cnt1}, 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_stream_demux
